fifo_param: RTL and testbench

Parametrised synchronous single-clock FIFO. It is the successor to the fixed 32-bit FIFO used on accelerator data paths.
- Adds configurable width, depth and thresholds.
- Adds an occupancy count and almost-full / almost-empty flags.
- Adds an optional first-word-fall-through (FWFT) read mode.
- Adds sticky overflow/underflow error flags.
It sits between producer and consumer stages of the accelerator pipeline.

---
 rtl/fifo_param.sv | 136 +++++++++++++
 tb/tb_fifo_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky
// error flags and an optional first-word-fall-through read port.
module fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic                       r_en,
    input  logic                       err_clr,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_param: DEPTH=%0d must be a power of 2 and >= 2", DEPTH);
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_param: AF_THRESH=%0d outside 1..DEPTH", AF_THRESH);
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("fifo_param: AE_THRESH=%0d outside 0..DEPTH-1", AE_THRESH);
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic                  ptr_empty, ptr_full, rd_ok, wr_ok;

    // The MSB of each pointer is a wrap bit, so equal addresses mean either
    // empty (same lap) or full (one lap apart).
    assign ptr_empty = (wr_ptr == rd_ptr);
    assign ptr_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_ok      = r_en & ~ptr_empty;
        wr_ok      = w_en & (~ptr_full | rd_ok);
        wr_ptr_nxt = wr_ptr + PW'(wr_ok);
        rd_ptr_nxt = rd_ptr + PW'(rd_ok);
        count_nxt  = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + PW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - PW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= (int'(count_nxt) == DEPTH);
            empty        <= (count_nxt == '0);
            almost_full  <= (int'(count_nxt) >= AF_THRESH);
            almost_empty <= (int'(count_nxt) <= AE_THRESH);
        end
    end

    // Set beats clear so an error in the clearing cycle is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && !wr_ok) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (r_en && ptr_empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    if (FWFT != 0) begin : g_fwft
        logic [DATA_WIDTH-1:0] head_nxt;

        // When the new head is the word being written this edge, take it from
        // data_in since the array does not hold it yet.
        assign head_nxt = (rd_ptr_nxt == wr_ptr) ? data_in : mem[rd_ptr_nxt[AW-1:0]];

        always_ff @(posedge clk) begin
            if (rst) begin
                data_out <= '0;
            end else if (rd_ok || (ptr_empty && wr_ok)) begin
                data_out <= head_nxt;
            end
        end
    end else begin : g_std
        always_ff @(posedge clk) begin
            if (rst) begin
                data_out <= '0;
            end else if (rd_ok) begin
                data_out <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: one standard-read and one FWFT instance,
// directed stimulus with expected words queued at write time.
module tb_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Standard-read instance
    logic        rst0 = 1'b0, w_en0 = 1'b0, r_en0 = 1'b0, err_clr0 = 1'b0;
    logic [31:0] data_in0 = '0, data_out0;
    logic        full0, empty0, af0, ae0, ovf0, udf0;
    logic [4:0]  count0;

    // FWFT instance
    logic        rst1 = 1'b0, w_en1 = 1'b0, r_en1 = 1'b0, err_clr1 = 1'b0;
    logic [31:0] data_in1 = '0, data_out1;
    logic        full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0]  count1;

    fifo_param #(.DATA_WIDTH(32), .DEPTH(16), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst0), .w_en(w_en0), .r_en(r_en0), .err_clr(err_clr0),
        .data_in(data_in0), .data_out(data_out0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(udf0)
    );

    fifo_param #(.DATA_WIDTH(32), .DEPTH(16), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst1), .w_en(w_en1), .r_en(r_en1), .err_clr(err_clr1),
        .data_in(data_in1), .data_out(data_out1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(udf1)
    );

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int m_cnt0 = 0;
    int m_cnt1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk0(input string tag, input int cnt, input logic fl, input logic afl,
                        input logic em, input logic ael);
        check({tag, ".count"}, 32'(count0), 32'(cnt));
        check({tag, ".full"}, 32'(full0), 32'(fl));
        check({tag, ".almost_full"}, 32'(af0), 32'(afl));
        check({tag, ".empty"}, 32'(empty0), 32'(em));
        check({tag, ".almost_empty"}, 32'(ae0), 32'(ael));
    endtask

    task automatic op0(input logic w, input logic r, input logic [31:0] d, input logic clr);
        bit rd_acc, wr_acc;
        rd_acc = r && (m_cnt0 > 0);
        wr_acc = w && ((m_cnt0 < 16) || rd_acc);
        if (wr_acc) q0.push_back(d);
        m_cnt0 = m_cnt0 + int'(wr_acc) - int'(rd_acc);
        w_en0 = w; r_en0 = r; data_in0 = d; err_clr0 = clr;
        @(posedge clk); #1;
        w_en0 = 1'b0; r_en0 = 1'b0; err_clr0 = 1'b0;
    endtask

    task automatic op1(input logic w, input logic r, input logic [31:0] d);
        bit rd_acc, wr_acc;
        rd_acc = r && (m_cnt1 > 0);
        wr_acc = w && ((m_cnt1 < 16) || rd_acc);
        if (wr_acc) q1.push_back(d);
        m_cnt1 = m_cnt1 + int'(wr_acc) - int'(rd_acc);
        w_en1 = w; r_en1 = r; data_in1 = d;
        @(posedge clk); #1;
        w_en1 = 1'b0; r_en1 = 1'b0;
    endtask

    // Reset is held with both requests active; the FIFO must ignore them.
    task automatic reset0(input int n);
        rst0 = 1'b1; w_en0 = 1'b1; r_en0 = 1'b1; data_in0 = 32'hFFFF_FFFF;
        repeat (n) @(posedge clk);
        #1;
        rst0 = 1'b0; w_en0 = 1'b0; r_en0 = 1'b0;
        q0.delete(); m_cnt0 = 0;
    endtask

    task automatic reset1(input int n);
        rst1 = 1'b1; w_en1 = 1'b1; r_en1 = 1'b1; data_in1 = 32'hFFFF_FFFF;
        repeat (n) @(posedge clk);
        #1;
        rst1 = 1'b0; w_en1 = 1'b0; r_en1 = 1'b0;
        q1.delete(); m_cnt1 = 0;
    endtask

    // Standard-read monitor: an accepted read presents its word after the edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst0 && r_en0 && empty0 === 1'b0) begin
                @(negedge clk);
                if (q0.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL std_rd_unexpected: got 0x%0h expected no read", data_out0);
                end else begin
                    check("std_rd_data", data_out0, q0.pop_front());
                end
            end
        end
    end

    // FWFT monitor: the head word is compared in the cycle it is popped.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst1 && r_en1 && empty1 === 1'b0) begin
                if (q1.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL fwft_pop_unexpected: got 0x%0h expected no pop", data_out1);
                end else begin
                    check("fwft_head", data_out1, q1.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;

        // Reset with both requests held high
        reset0(3);
        reset1(3);
        chk0("reset", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("reset.data_out", data_out0, 32'h0);
        check("reset.overflow", 32'(ovf0), 32'h0);
        check("reset.underflow", 32'(udf0), 32'h0);

        // Fill to full, overflow, drain in order
        for (int i = 1; i <= 16; i++) begin
            op0(1'b1, 1'b0, 32'(i), 1'b0);
            if (i == 2)  chk0("fill2", 2, 1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 3)  chk0("fill3", 3, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 13) chk0("fill13", 13, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 14) chk0("fill14", 14, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 15) chk0("fill15", 15, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk0("full16", 16, 1'b1, 1'b1, 1'b0, 1'b0);
        check("full16.overflow", 32'(ovf0), 32'h0);
        op0(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        check("ovf.overflow", 32'(ovf0), 32'h1);
        chk0("ovf", 16, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (16) op0(1'b0, 1'b1, 32'h0, 1'b0);
        #1;
        chk0("drained", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("drained.data_out_last", data_out0, 32'h10);
        check("drained.underflow", 32'(udf0), 32'h0);

        // Simultaneous read+write while full, then while empty
        for (int i = 1; i <= 16; i++) op0(1'b1, 1'b0, 32'h100 + 32'(i), 1'b0);
        for (int i = 1; i <= 4; i++) begin
            op0(1'b1, 1'b1, 32'h200 + 32'(i), 1'b0);
            chk0("full_rw", 16, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        repeat (16) op0(1'b0, 1'b1, 32'h0, 1'b0);
        op0(1'b0, 1'b0, 32'h0, 1'b1);
        check("clr.overflow", 32'(ovf0), 32'h0);
        op0(1'b1, 1'b1, 32'h55, 1'b0);
        chk0("empty_rw", 1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("empty_rw.underflow", 32'(udf0), 32'h1);
        op0(1'b0, 1'b1, 32'h0, 1'b0);

        // Wrap-around: interleaved write/read pairs
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            op0(1'b1, 1'b0, r, 1'b0);
            check("wrap.count_w", 32'(count0), 32'h1);
            op0(1'b0, 1'b1, 32'h0, 1'b0);
            check("wrap.count_r", 32'(count0), 32'h0);
        end

        // Error flags: set wins over clear
        op0(1'b0, 1'b0, 32'h0, 1'b1);
        check("err.clr_first", 32'(udf0), 32'h0);
        op0(1'b0, 1'b1, 32'h0, 1'b0);
        check("err.udf_set", 32'(udf0), 32'h1);
        op0(1'b0, 1'b1, 32'h0, 1'b1);
        check("err.set_wins", 32'(udf0), 32'h1);
        op0(1'b0, 1'b0, 32'h0, 1'b1);
        check("err.clr_alone", 32'(udf0), 32'h0);

        // Reset mid-fill discards contents
        for (int i = 1; i <= 7; i++) op0(1'b1, 1'b0, 32'h300 + 32'(i), 1'b0);
        chk0("fill7", 7, 1'b0, 1'b0, 1'b0, 1'b0);
        reset0(1);
        chk0("mid_rst", 0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("mid_rst.data_out", data_out0, 32'h0);
        op0(1'b1, 1'b0, 32'h777, 1'b0);
        op0(1'b0, 1'b1, 32'h0, 1'b0);

        // FWFT: head word visible without a read request
        op1(1'b1, 1'b0, 32'hA5A5_A5A5);
        check("fwft.empty_after_wr", 32'(empty1), 32'h0);
        check("fwft.head_no_ren", data_out1, 32'hA5A5_A5A5);
        op1(1'b1, 1'b0, 32'h1111_1111);
        op1(1'b1, 1'b0, 32'h2222_2222);
        op1(1'b0, 1'b1, 32'h0);
        op1(1'b0, 1'b0, 32'h0);
        check("fwft.next_head", data_out1, 32'h1111_1111);
        check("fwft.count2", 32'(count1), 32'h2);
        op1(1'b0, 1'b1, 32'h0);
        op1(1'b1, 1'b1, 32'h3333_3333);
        check("fwft.bypass_head", data_out1, 32'h3333_3333);
        check("fwft.count1", 32'(count1), 32'h1);
        op1(1'b0, 1'b1, 32'h0);
        check("fwft.empty_last", 32'(empty1), 32'h1);
        check("fwft.underflow", 32'(udf1), 32'h0);

        repeat (2) @(posedge clk);
        #1;
        check("std_queue_drained", 32'(q0.size()), 32'h0);
        check("fwft_queue_drained", 32'(q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
